seq_detect_ctrl: RTL

Frame-based controller around a programmable serial sequence detector. Software configures a pattern of up to MAX_LEN bits and starts a scan of a fixed-length frame. The block then accepts the serial bitstream under a valid/ready handshake and flags every pattern match (Mealy-style, in the cycle of the completing bit). At frame end it reports a saturating match count. It sits between the bit source and the status logic, replacing hard-wired single-pattern FSM detectors.

---
 rtl/seq_detect_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
//   Frame-based controller around a programmable serial sequence detector.
//   Software loads a pattern of 2..MAX_LEN bits, then starts a scan of a
//   frame of frame_len bits. Bits arrive under in_valid/in_ready. match is
//   raised in the cycle of the bit that completes the pattern. A saturating
//   match count is kept for the frame, and done pulses at frame end.
//
//   Optional feature macro: SEQ_DETECT_CTRL_OVERLAP_EN
//     defined   : overlapping detection (history and fill kept after a match)
//     undefined : non-overlapping detection (fill cleared on a match)
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   cfg_we            configuration load (IDLE only)
//   cfg_pattern       pattern; bit cfg_len-1 is received first, bit 0 last
//   cfg_len           pattern length
//   cfg_err           sticky: last cfg_we carried an illegal length
//   start, frame_len  begin a scan of frame_len bits (IDLE only)
//   abort             end a scan early, without a done pulse
//   in_valid, in      serial bit stream
//   in_ready          high while scanning
//   match             combinational match flag for the accepted bit
//   busy, done        scanning / one-cycle end-of-frame pulse
//   match_count       saturating match count of current or last frame
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int FRAME_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  output logic               cfg_err,
  input  logic               start,
  input  logic               abort,
  input  logic [FRAME_W-1:0] frame_len,
  input  logic               in_valid,
  input  logic               in,
  output logic               in_ready,
  output logic               match,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   match_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [3:0]         len_q, len_d;
  logic               cfg_err_q, cfg_err_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [3:0]         fill_q, fill_d;
  logic [FRAME_W-1:0] bits_left_q, bits_left_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               cfg_ok;
  logic               accept;
  logic [MAX_LEN-1:0] hist_shift;
  logic [3:0]         fill_inc;
  logic [MAX_LEN-1:0] len_mask;
  logic               hit;

  always_comb begin
    cfg_ok     = (cfg_len >= 4'd2) && (32'(cfg_len) <= MAX_LEN);
    accept     = (state_q == S_SCAN) && in_valid;
    hist_shift = {hist_q[MAX_LEN-2:0], in};
    fill_inc   = (fill_q < len_q) ? fill_q + 4'd1 : fill_q;
    len_mask   = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < 32'(len_q));
    end
    // Only the newest len bits of history take part in the compare.
    hit = accept && (fill_inc == len_q) &&
          (((hist_shift ^ pattern_q) & len_mask) == '0);
  end

  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    len_d       = len_q;
    cfg_err_d   = cfg_err_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    bits_left_d = bits_left_q;
    count_d     = count_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          if (cfg_ok) begin
            pattern_d = cfg_pattern;
            len_d     = cfg_len;
            cfg_err_d = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        // cfg_err_d already reflects a same-cycle cfg_we, so a start
        // paired with a legal configuration is honoured with it.
        if (start && !cfg_err_d) begin
          count_d     = '0;
          hist_d      = '0;
          fill_d      = '0;
          bits_left_d = frame_len;
          state_d     = (frame_len == '0) ? S_DONE : S_SCAN;
        end
      end
      S_SCAN: begin
        if (accept) begin
          hist_d      = hist_shift;
          fill_d      = fill_inc;
          bits_left_d = bits_left_q - 1'b1;
          if (hit) begin
            if (count_q != '1) begin
              count_d = count_q + 1'b1;
            end
`ifndef SEQ_DETECT_CTRL_OVERLAP_EN
            fill_d = '0;
`endif
          end
          if (bits_left_q == {{(FRAME_W-1){1'b0}}, 1'b1}) begin
            state_d = S_DONE;
          end
        end
        if (abort) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pattern_q   <= '0;
      len_q       <= 4'd3;
      cfg_err_q   <= 1'b0;
      hist_q      <= '0;
      fill_q      <= '0;
      bits_left_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      len_q       <= len_d;
      cfg_err_q   <= cfg_err_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      bits_left_q <= bits_left_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    busy        = (state_q == S_SCAN);
    in_ready    = (state_q == S_SCAN);
    done        = (state_q == S_DONE);
    match       = hit;
    match_count = count_q;
    cfg_err     = cfg_err_q;
  end

endmodule
